// File: rtl/anc_pkg.sv
// Shared types and constants for the ANC sample path: widths, saturation limits
// and the LMS sequencer state encoding.
package anc_pkg;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned ACC_W    = 32;

   localparam int SAT_MAX = 32767;
   localparam int SAT_MIN = -32768;

   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef logic signed [ACC_W-1:0]    acc_t;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StOut
   } lms_seq_state_t;

endpackage

// File: rtl/anc_lms_sequencer_if.sv
// Bundle of the ADC-side, LMS-core-side and DAC-side signals of the sequencer.
// The master side drives samples and core results; the slave side is the sequencer.
interface anc_lms_sequencer_if;
   import anc_pkg::*;

   logic    ref_valid;
   logic    ref_ready;
   sample_t ref_sample;
   logic    err_valid;
   logic    err_ready;
   sample_t err_sample;
   sample_t mu_cfg;
   logic    lms_in_valid;
   sample_t lms_in_sample;
   sample_t lms_error_in;
   sample_t lms_u_in;
   logic    lms_out_valid;
   acc_t    lms_out_sample;
   logic    y_valid;
   logic    y_ready;
   sample_t y_sample;
   logic [15:0] timeout_count;
   logic    busy;

   modport master (
      output ref_valid, ref_sample, err_valid, err_sample, mu_cfg,
             lms_out_valid, lms_out_sample, y_ready,
      input  ref_ready, err_ready, lms_in_valid, lms_in_sample, lms_error_in, lms_u_in,
             y_valid, y_sample, timeout_count, busy
   );

   modport slave (
      input  ref_valid, ref_sample, err_valid, err_sample, mu_cfg,
             lms_out_valid, lms_out_sample, y_ready,
      output ref_ready, err_ready, lms_in_valid, lms_in_sample, lms_error_in, lms_u_in,
             y_valid, y_sample, timeout_count, busy
   );

endinterface

// File: rtl/anc_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation from an
// ACC_W accumulator value to a SAMPLE_W sample.
module anc_round_sat
   import anc_pkg::*;
#(
   parameter int unsigned Shift = 15
) (
   input  acc_t    acc_i,
   output sample_t sample_o
);

   localparam logic signed [ACC_W:0] Half   = (ACC_W+1)'(1) << (Shift - 1);
   localparam logic signed [ACC_W:0] MaxExt = (ACC_W+1)'(SAT_MAX);
   localparam logic signed [ACC_W:0] MinExt = (ACC_W+1)'(SAT_MIN);

   logic signed [ACC_W:0] ext;
   logic signed [ACC_W:0] shifted;

   always_comb begin
      ext     = {acc_i[ACC_W-1], acc_i};
      // One guard bit keeps the rounding add from wrapping at the positive limit.
      shifted = (ext + Half) >>> Shift;
      if (shifted > MaxExt) begin
         sample_o = MaxExt[SAMPLE_W-1:0];
      end else if (shifted < MinExt) begin
         sample_o = MinExt[SAMPLE_W-1:0];
      end else begin
         sample_o = shifted[SAMPLE_W-1:0];
      end
   end

endmodule

// File: rtl/anc_lms_sequencer.sv
// Pairs reference/error samples, strobes them into the LMS core, waits for the
// result (with timeout) and presents the rounded anti-noise sample to the DAC.
module anc_lms_sequencer
   import anc_pkg::*;
#(
   parameter int unsigned OUT_SHIFT      = 15,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic           clk,
   input logic           rst_n,
   anc_lms_sequencer_if.slave bus
);

   localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

   lms_seq_state_t  state_q, state_d;
   logic            ref_full_q, ref_full_d, err_full_q, err_full_d;
   sample_t         ref_data_q, ref_data_d, err_data_q, err_data_d;
   sample_t         in_sample_q, in_sample_d, err_in_q, err_in_d, mu_q, mu_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            prev_valid_q;
   sample_t         y_q, y_d;
   logic [15:0]     tmo_q, tmo_d;
   sample_t         rounded;
   logic            out_edge;
   logic            issue;

   anc_round_sat #(
      .Shift (OUT_SHIFT)
   ) u_round_sat (
      .acc_i    (bus.lms_out_sample),
      .sample_o (rounded)
   );

   assign out_edge = bus.lms_out_valid && !prev_valid_q;
   assign issue    = (state_q == StIssue);

   always_comb begin
      state_d     = state_q;
      ref_full_d  = ref_full_q;
      err_full_d  = err_full_q;
      ref_data_d  = ref_data_q;
      err_data_d  = err_data_q;
      in_sample_d = in_sample_q;
      err_in_d    = err_in_q;
      mu_d        = mu_q;
      cnt_d       = cnt_q;
      y_d         = y_q;
      tmo_d       = tmo_q;

      // Holding registers stage the next frame in any state.
      if (bus.ref_valid && !ref_full_q) begin
         ref_full_d = 1'b1;
         ref_data_d = bus.ref_sample;
      end
      if (bus.err_valid && !err_full_q) begin
         err_full_d = 1'b1;
         err_data_d = bus.err_sample;
      end

      unique case (state_q)
         StIdle: begin
            if (ref_full_q && err_full_q) state_d = StIssue;
         end
         StIssue: begin
            ref_full_d  = 1'b0;
            err_full_d  = 1'b0;
            cnt_d       = '0;
            in_sample_d = ref_data_q;
            err_in_d    = err_data_q;
            mu_d        = bus.mu_cfg;
            state_d     = StWait;
         end
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            if (out_edge) begin
               y_d     = rounded;
               state_d = StOut;
            end else if (cnt_q == CntLast) begin
               y_d     = '0;
               if (tmo_q != 16'hFFFF) tmo_d = tmo_q + 16'd1;
               state_d = StOut;
            end
         end
         StOut: begin
            if (bus.y_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ref_full_q   <= 1'b0;
         err_full_q   <= 1'b0;
         ref_data_q   <= '0;
         err_data_q   <= '0;
         in_sample_q  <= '0;
         err_in_q     <= '0;
         mu_q         <= '0;
         cnt_q        <= '0;
         prev_valid_q <= 1'b0;
         y_q          <= '0;
         tmo_q        <= '0;
      end else begin
         state_q      <= state_d;
         ref_full_q   <= ref_full_d;
         err_full_q   <= err_full_d;
         ref_data_q   <= ref_data_d;
         err_data_q   <= err_data_d;
         in_sample_q  <= in_sample_d;
         err_in_q     <= err_in_d;
         mu_q         <= mu_d;
         cnt_q        <= cnt_d;
         prev_valid_q <= bus.lms_out_valid;
         y_q          <= y_d;
         tmo_q        <= tmo_d;
      end
   end

   assign bus.ref_ready     = !ref_full_q;
   assign bus.err_ready     = !err_full_q;
   assign bus.lms_in_valid  = issue;
   assign bus.lms_in_sample = issue ? ref_data_q : in_sample_q;
   assign bus.lms_error_in  = issue ? err_data_q : err_in_q;
   assign bus.lms_u_in      = issue ? bus.mu_cfg : mu_q;
   assign bus.y_valid       = (state_q == StOut);
   assign bus.y_sample      = y_q;
   assign bus.timeout_count = tmo_q;
   assign bus.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_anc_lms_sequencer.sv
// Directed self-checking bench for anc_lms_sequencer (TIMEOUT_CYCLES = 8).
module tb_anc_lms_sequencer;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   anc_lms_sequencer_if bus ();

   anc_lms_sequencer #(
      .OUT_SHIFT      (15),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_pair(input logic signed [15:0] r, input logic signed [15:0] e,
                            output bit ok);
      logic rr, er;
      bus.ref_sample = r;
      bus.err_sample = e;
      bus.ref_valid  = 1'b1;
      bus.err_valid  = 1'b1;
      for (int n = 0; n < 40 && (bus.ref_valid || bus.err_valid); n++) begin
         rr = bus.ref_ready;
         er = bus.err_ready;
         tick();
         if (rr) bus.ref_valid = 1'b0;
         if (er) bus.err_valid = 1'b0;
      end
      ok = !(bus.ref_valid || bus.err_valid);
      bus.ref_valid = 1'b0;
      bus.err_valid = 1'b0;
   endtask

   task automatic wait_issue(output bit found);
      found = 1'b0;
      for (int n = 0; n < 10 && !found; n++) begin
         if (bus.lms_in_valid) found = 1'b1;
         else tick();
      end
   endtask

   task automatic test_reset();
      checks++;
      if (bus.ref_ready !== 1'b1 || bus.err_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got ref=%b err=%b, want 1/1", bus.ref_ready, bus.err_ready);
      end
      checks++;
      if (bus.lms_in_valid !== 1'b0 || bus.y_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got in_valid=%b y_valid=%b busy=%b, want 0/0/0",
                  bus.lms_in_valid, bus.y_valid, bus.busy);
      end
      checks++;
      if (bus.lms_in_sample !== 16'sd0 || bus.lms_error_in !== 16'sd0 ||
          bus.lms_u_in !== 16'sd0 || bus.y_sample !== 16'sd0 || bus.timeout_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_data: got in=%0d err=%0d u=%0d y=%0d tmo=%0d, want all 0",
                  bus.lms_in_sample, bus.lms_error_in, bus.lms_u_in, bus.y_sample,
                  bus.timeout_count);
      end
   endtask

   task automatic test_basic();
      bit ok;
      int pulses;
      bus.mu_cfg  = 16'sd100;
      bus.y_ready = 1'b1;
      push_pair(16'sd200, 16'sd800, ok);
      checks++;
      if (!ok || bus.lms_in_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_accept: got ok=%b in_valid=%b, want 1/0", ok, bus.lms_in_valid);
      end
      tick();
      checks++;
      if (bus.lms_in_valid !== 1'b1 || bus.lms_in_sample !== 16'sd200 ||
          bus.lms_error_in !== 16'sd800 || bus.lms_u_in !== 16'sd100) begin
         errors++;
         $display("FAIL basic_issue: got v=%b %0d/%0d/%0d, want 1 200/800/100",
                  bus.lms_in_valid, bus.lms_in_sample, bus.lms_error_in, bus.lms_u_in);
      end
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.lms_in_valid) pulses++;
      end
      checks++;
      if (pulses != 0 || bus.busy !== 1'b1 || bus.lms_in_sample !== 16'sd200 ||
          bus.y_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_wait: got extra_pulses=%0d busy=%b in=%0d y_valid=%b, want 0/1/200/0",
                  pulses, bus.busy, bus.lms_in_sample, bus.y_valid);
      end
      bus.lms_out_sample = 32'sh0001_0000;
      bus.lms_out_valid  = 1'b1;
      tick();
      bus.lms_out_valid = 1'b0;
      checks++;
      if (bus.y_valid !== 1'b1 || bus.y_sample !== 16'sd2) begin
         errors++;
         $display("FAIL basic_result: got y_valid=%b y=%0d, want 1/2", bus.y_valid, bus.y_sample);
      end
      tick();
      checks++;
      if (bus.y_valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: got y_valid=%b busy=%b, want 0/0", bus.y_valid, bus.busy);
      end
   endtask

   task automatic test_round_sat();
      logic signed [31:0] acc_v [3];
      logic signed [15:0] exp_v [3];
      bit ok, found;
      acc_v[0] = 32'sh0000_4000; exp_v[0] = 16'sd1;
      acc_v[1] = 32'sh7FFF_FFFF; exp_v[1] = 16'sd32767;
      acc_v[2] = 32'sh8000_0000; exp_v[2] = -16'sd32768;
      bus.y_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_pair(16'sd1, 16'sd2, ok);
         wait_issue(found);
         tick();
         bus.lms_out_sample = acc_v[i];
         bus.lms_out_valid  = 1'b1;
         tick();
         bus.lms_out_valid = 1'b0;
         checks++;
         if (!ok || !found || bus.y_valid !== 1'b1 || bus.y_sample !== exp_v[i]) begin
            errors++;
            $display("FAIL round_sat[%0d]: got ok=%b found=%b y_valid=%b y=%0d, want y=%0d",
                     i, ok, found, bus.y_valid, bus.y_sample, exp_v[i]);
         end
         tick();
      end
   endtask

   task automatic test_timeout();
      bit ok, found;
      int lat;
      bus.y_ready = 1'b0;
      push_pair(16'sd5, 16'sd6, ok);
      wait_issue(found);
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         tick();
         if (bus.y_valid) lat = k;
      end
      checks++;
      if (!ok || !found || lat != 9) begin
         errors++;
         $display("FAIL timeout_latency: got %0d cycles (found=%b), want 9", lat, found);
      end
      checks++;
      if (bus.y_sample !== 16'sd0 || bus.timeout_count !== 16'd1) begin
         errors++;
         $display("FAIL timeout_value: got y=%0d count=%0d, want 0/1", bus.y_sample,
                  bus.timeout_count);
      end
      bus.lms_out_sample = 32'sh0001_0000;
      bus.lms_out_valid  = 1'b1;
      tick();
      tick();
      checks++;
      if (bus.y_valid !== 1'b1 || bus.y_sample !== 16'sd0) begin
         errors++;
         $display("FAIL timeout_late_edge: got y_valid=%b y=%0d, want 1/0", bus.y_valid,
                  bus.y_sample);
      end
      bus.lms_out_valid = 1'b0;
      bus.y_ready       = 1'b1;
      tick();
      // A late edge must not leave a pending capture behind.
      push_pair(16'sd7, 16'sd8, ok);
      wait_issue(found);
      tick();
      tick();
      tick();
      checks++;
      if (!found || bus.y_valid !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_no_stored_edge: got found=%b y_valid=%b busy=%b, want 1/0/1",
                  found, bus.y_valid, bus.busy);
      end
      bus.lms_out_sample = 32'sh0000_4000;
      bus.lms_out_valid  = 1'b1;
      tick();
      bus.lms_out_valid = 1'b0;
      checks++;
      if (bus.y_valid !== 1'b1 || bus.y_sample !== 16'sd1 || bus.timeout_count !== 16'd1) begin
         errors++;
         $display("FAIL timeout_recover: got y_valid=%b y=%0d count=%0d, want 1/1/1",
                  bus.y_valid, bus.y_sample, bus.timeout_count);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      bit ok, ok2, found, stable;
      bus.y_ready = 1'b0;
      push_pair(16'sd10, 16'sd20, ok);
      wait_issue(found);
      tick();
      bus.lms_out_sample = 32'sh0002_0000;
      bus.lms_out_valid  = 1'b1;
      tick();
      bus.lms_out_valid = 1'b0;
      checks++;
      if (!found || bus.y_valid !== 1'b1 || bus.y_sample !== 16'sd4) begin
         errors++;
         $display("FAIL bp_result: got found=%b y_valid=%b y=%0d, want 1/1/4", found,
                  bus.y_valid, bus.y_sample);
      end
      push_pair(16'sd30, 16'sd40, ok2);
      checks++;
      if (!ok || !ok2) begin
         errors++;
         $display("FAIL bp_stage: got accept=%b/%b, want 1/1", ok, ok2);
      end
      stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bus.y_valid !== 1'b1 || bus.y_sample !== 16'sd4 || bus.lms_in_valid !== 1'b0)
            stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL bp_hold: got y_valid=%b y=%0d stable=%b, want 1/4/1", bus.y_valid,
                  bus.y_sample, stable);
      end
      bus.y_ready = 1'b1;
      tick();
      checks++;
      if (bus.y_valid !== 1'b0 || bus.lms_in_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_handshake: got y_valid=%b in_valid=%b, want 0/0", bus.y_valid,
                  bus.lms_in_valid);
      end
      tick();
      checks++;
      if (bus.lms_in_valid !== 1'b1 || bus.lms_in_sample !== 16'sd30 ||
          bus.lms_error_in !== 16'sd40 || bus.ref_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_next_issue: got v=%b %0d/%0d ref_ready=%b, want 1 30/40 0",
                  bus.lms_in_valid, bus.lms_in_sample, bus.lms_error_in, bus.ref_ready);
      end
      bus.ref_sample = 16'sd99;
      bus.ref_valid  = 1'b1;
      tick();
      bus.ref_valid = 1'b0;
      checks++;
      if (bus.ref_ready !== 1'b1 || bus.lms_in_sample !== 16'sd30) begin
         errors++;
         $display("FAIL issue_no_accept: got ref_ready=%b in=%0d, want 1/30", bus.ref_ready,
                  bus.lms_in_sample);
      end
      bus.lms_out_sample = 32'sh0000_4000;
      bus.lms_out_valid  = 1'b1;
      tick();
      bus.lms_out_valid = 1'b0;
      checks++;
      if (bus.y_valid !== 1'b1 || bus.y_sample !== 16'sd1) begin
         errors++;
         $display("FAIL bp_second: got y_valid=%b y=%0d, want 1/1", bus.y_valid, bus.y_sample);
      end
      tick();
   endtask

   task automatic test_stale_level();
      bit ok, found, seen;
      bus.y_ready        = 1'b1;
      bus.lms_out_sample = 32'sh0001_0000;
      bus.lms_out_valid  = 1'b1;
      push_pair(16'sd3, 16'sd4, ok);
      wait_issue(found);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.y_valid) seen = 1'b1;
      end
      checks++;
      if (!ok || !found || seen || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL stale_level: got found=%b y_seen=%b busy=%b, want 1/0/1", found, seen,
                  bus.busy);
      end
      bus.lms_out_valid = 1'b0;
      tick();
      bus.lms_out_valid = 1'b1;
      tick();
      bus.lms_out_valid = 1'b0;
      checks++;
      if (bus.y_valid !== 1'b1 || bus.y_sample !== 16'sd2) begin
         errors++;
         $display("FAIL stale_reedge: got y_valid=%b y=%0d, want 1/2", bus.y_valid, bus.y_sample);
      end
      tick();
   endtask

   task automatic test_reset_mid_wait();
      bit ok, found;
      bus.y_ready = 1'b1;
      push_pair(16'sd11, 16'sd12, ok);
      wait_issue(found);
      tick();
      bus.ref_sample = 16'sd13;
      bus.ref_valid  = 1'b1;
      tick();
      bus.ref_valid      = 1'b0;
      bus.lms_out_sample = 32'sh0001_0000;
      bus.lms_out_valid  = 1'b1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.ref_ready !== 1'b1 || bus.lms_in_sample !== 16'sd0 ||
          bus.y_sample !== 16'sd0 || bus.timeout_count !== 16'd0 || bus.y_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_wait: got busy=%b ref_ready=%b in=%0d y=%0d tmo=%0d yv=%b",
                  bus.busy, bus.ref_ready, bus.lms_in_sample, bus.y_sample, bus.timeout_count,
                  bus.y_valid);
      end
      tick();
      bus.lms_out_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_basic();
   endtask

   initial begin
      checks             = 0;
      errors             = 0;
      rst_n              = 1'b0;
      bus.ref_valid      = 1'b0;
      bus.ref_sample     = '0;
      bus.err_valid      = 1'b0;
      bus.err_sample     = '0;
      bus.mu_cfg         = '0;
      bus.lms_out_valid  = 1'b0;
      bus.lms_out_sample = '0;
      bus.y_ready        = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_basic();
      test_round_sat();
      test_timeout();
      test_back_to_back();
      test_stale_level();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
